// File: rtl/gemm_out_ram.sv
// GEMM output tile buffer: multi-port write with overwrite or saturating accumulate,
// per-entry written tracking, single registered read port.
module gemm_out_ram #(
    parameter int DATA_W = 19,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int NPORTS = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NPORTS-1:0]          wr_en,
    input  logic [NPORTS*ADDR_W-1:0]   wr_addr,
    input  logic [NPORTS*DATA_W-1:0]   wr_data,
    input  logic                       acc_mode,
    input  logic                       clear,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic signed [DATA_W-1:0]   rd_data,
    output logic                       rd_valid,
    output logic [ADDR_W:0]            wr_count,
    output logic                       full,
    output logic                       collision_err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int SUM_W = DATA_W + $clog2(NPORTS + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]         written;

    logic [ADDR_W-1:0]        addr [NPORTS];
    logic signed [DATA_W-1:0] data [NPORTS];
    logic signed [SUM_W-1:0]  sum  [NPORTS];
    logic signed [DATA_W-1:0] wval [NPORTS];
    logic [NPORTS-1:0]        valid;
    logic [NPORTS-1:0]        win;
    logic                     collide;
    logic [CNT_W-1:0]         new_cnt;
    logic [DEPTH-1:0]         set_mask;
    logic signed [DATA_W-1:0] rd_word;

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [SUM_W-1:0] s);
        if (s > SAT_MAX)
            return SAT_MAX[DATA_W-1:0];
        else if (s < SAT_MIN)
            return SAT_MIN[DATA_W-1:0];
        else
            return s[DATA_W-1:0];
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NPORTS; i++) begin
            addr[i]  = wr_addr[i*ADDR_W +: ADDR_W];
            data[i]  = wr_data[i*DATA_W +: DATA_W];
            valid[i] = wr_en[i] && ({1'b0, addr[i]} < DEPTH_C);
        end
    end

    // Only the highest-index port targeting an address commits; in accumulate mode its
    // value already carries the sum of every port hitting that address, so one write suffices.
    always_comb begin
        win      = '0;
        collide  = 1'b0;
        new_cnt  = '0;
        set_mask = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            win[i] = valid[i];
            sum[i] = (valid[i] && written[addr[i]]) ? SUM_W'(mem[addr[i]]) : '0;
            for (int unsigned j = 0; j < NPORTS; j++) begin
                if (valid[i] && valid[j] && addr[j] == addr[i]) begin
                    sum[i] = sum[i] + SUM_W'(data[j]);
                    if (j > i) begin
                        win[i] = 1'b0;
                        if (!acc_mode)
                            collide = 1'b1;
                    end
                end
            end
            wval[i] = acc_mode ? saturate(sum[i]) : data[i];
            if (win[i]) begin
                set_mask[addr[i]] = 1'b1;
                if (!written[addr[i]])
                    new_cnt = new_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (({1'b0, rd_addr} < DEPTH_C) && written[rd_addr])
            rd_word = mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst_n && !clear) begin
            for (int unsigned i = 0; i < NPORTS; i++) begin
                if (win[i])
                    mem[addr[i]] <= wval[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written       <= '0;
            wr_count      <= '0;
            collision_err <= 1'b0;
            rd_data       <= '0;
            rd_valid      <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_word;
            if (clear) begin
                written       <= '0;
                wr_count      <= '0;
                collision_err <= 1'b0;
            end else begin
                written  <= written | set_mask;
                wr_count <= wr_count + new_cnt;
                if (collide)
                    collision_err <= 1'b1;
            end
        end
    end

    assign full = (wr_count == DEPTH_C);

endmodule
